// File: rtl/radar_filter_pkg.sv
// Shared constants for the radar point filter chain: point format, window
// geometry and the streamer FSM encoding.
package radar_filter_pkg;

  localparam int POINT_W    = 128;
  localparam int WINDOW_LEN = 5;

  localparam logic [POINT_W-1:0] INVALID_POINT = '1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_PAD    = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

endpackage

// File: rtl/point_fifo2.sv
// Two-entry point FIFO that absorbs read data already in flight when the
// downstream stalls.
module point_fifo2
  import radar_filter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [POINT_W-1:0] push_data,
  input  logic               pop,
  output logic [POINT_W-1:0] head,
  output logic [1:0]         count
);

  logic [POINT_W-1:0] mem_q [2];
  logic [POINT_W-1:0] mem_d [2];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         count_q, count_d;

  always_comb begin
    // NOTE: combinational blocks use blocking '=' with a default first, so
    // every path assigns every signal and no latch is inferred.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    if (push) mem_d[wr_ptr_q] = push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; count_q alone decides what is valid, and
  // leaving the data flops without reset keeps them plain enable flops.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/radar_point_streamer.sv
// Streams one frame of points from point memory to the window buffer, then
// appends PAD_COUNT invalid points so the window drains.
module radar_point_streamer
  import radar_filter_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int PAD_COUNT = WINDOW_LEN - 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W:0]    frame_len,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_rd_addr,
  input  logic [POINT_W-1:0] mem_rd_data,
  output logic               valid_out,
  output logic [POINT_W-1:0] point_out,
  input  logic               ready_in,
  output logic               busy,
  output logic               done
);

  localparam int PAD_W = (PAD_COUNT > 1) ? $clog2(PAD_COUNT) : 1;

  logic [1:0]         state_q, state_d;
  logic [ADDR_W:0]    frame_len_q, frame_len_d;
  logic [ADDR_W:0]    rd_addr_q, rd_addr_d;
  logic               rd_pend_q, rd_pend_d;
  logic [PAD_W-1:0]   pad_cnt_q, pad_cnt_d;

  logic [1:0]         fifo_count;
  logic [POINT_W-1:0] fifo_head;
  logic               fifo_pop;
  logic               in_stream, in_pad, head_valid, xfer;
  logic [2:0]         occupancy;
  logic               last_point, last_pad;

  point_fifo2 u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pend_q),
    .push_data (mem_rd_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign in_stream  = (state_q == ST_STREAM);
  assign in_pad     = (state_q == ST_PAD);
  assign head_valid = in_stream && (fifo_count != 2'd0);
  assign valid_out  = head_valid || in_pad;
  assign xfer       = valid_out && ready_in;
  assign fifo_pop   = head_valid && ready_in;
  assign point_out  = head_valid ? fifo_head : INVALID_POINT;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_FINISH);

  // A slot freed by this cycle's pop may be refilled by this cycle's read.
  assign occupancy   = {1'b0, fifo_count} + {2'b00, rd_pend_q} - {2'b00, fifo_pop};
  assign mem_rd_en   = in_stream && (rd_addr_q < frame_len_q) && (occupancy < 3'd2);
  assign mem_rd_addr = rd_addr_q[ADDR_W-1:0];

  // The last point leaves when every read has landed and only one remains.
  assign last_point = fifo_pop && (fifo_count == 2'd1) && !rd_pend_q &&
                      (rd_addr_q == frame_len_q);
  assign last_pad   = in_pad && xfer && (pad_cnt_q == PAD_W'(PAD_COUNT - 1));

  always_comb begin
    state_d     = state_q;
    frame_len_d = frame_len_q;
    rd_addr_d   = rd_addr_q;
    pad_cnt_d   = pad_cnt_q;
    rd_pend_d   = mem_rd_en;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          frame_len_d = frame_len;
          rd_addr_d   = '0;
          state_d     = (frame_len == '0) ? ST_FINISH : ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (mem_rd_en) rd_addr_d = rd_addr_q + 1'b1;
        if (last_point) begin
          pad_cnt_d = '0;
          state_d   = (PAD_COUNT == 0) ? ST_FINISH : ST_PAD;
        end
      end
      ST_PAD: begin
        if (xfer) pad_cnt_d = pad_cnt_q + 1'b1;
        if (last_pad) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        rd_addr_d = '0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      frame_len_q <= '0;
      rd_addr_q   <= '0;
      rd_pend_q   <= 1'b0;
      pad_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      frame_len_q <= frame_len_d;
      rd_addr_q   <= rd_addr_d;
      rd_pend_q   <= rd_pend_d;
      pad_cnt_q   <= pad_cnt_d;
    end
  end

endmodule

// File: tb/tb_radar_point_streamer.sv
// Directed bench for radar_point_streamer: frames are queued into a scoreboard
// at stimulus time and a negedge monitor checks every transfer and read.
module tb_radar_point_streamer;
  import radar_filter_pkg::*;

  localparam int ADDR_W = 10;
  localparam int PAD    = WINDOW_LEN - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [ADDR_W:0]    frame_len = '0;
  logic               mem_rd_en;
  logic [ADDR_W-1:0]  mem_rd_addr;
  logic [POINT_W-1:0] mem_rd_data = '0;
  logic               valid_out;
  logic [POINT_W-1:0] point_out;
  logic               ready_in = 1'b0;
  logic               busy;
  logic               done;

  int n_checks = 0;
  int n_err    = 0;
  int done_seen = 0;
  int exp_done  = 0;

  logic [POINT_W-1:0] exp_pt_q [$];
  int                 exp_addr_q [$];

  logic               prev_stall = 1'b0;
  logic [POINT_W-1:0] prev_point = '0;

  radar_point_streamer #(.ADDR_W(ADDR_W), .PAD_COUNT(PAD)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .frame_len   (frame_len),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .valid_out   (valid_out),
    .point_out   (point_out),
    .ready_in    (ready_in),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  function automatic logic [POINT_W-1:0] pt(input int idx);
    logic [15:0] w;
    w = 16'(idx) ^ 16'h5A00;
    return {8{w}};
  endfunction

  // Point memory: data returns one cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= pt(int'(mem_rd_addr));
  end

  task automatic check(input string name, input logic [POINT_W-1:0] got,
                       input logic [POINT_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every transfer and every memory read.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        check("stall_valid_held", 128'(valid_out), 128'(1));
        if (valid_out) check("stall_point_held", point_out, prev_point);
      end
      if (valid_out && ready_in) begin
        if (exp_pt_q.size() == 0) check("unexpected_transfer", point_out, '0);
        else check("transfer_point", point_out, exp_pt_q.pop_front());
      end
      if (mem_rd_en) begin
        if (exp_addr_q.size() == 0) check("unexpected_read", 128'(mem_rd_addr), '1);
        else check("read_addr", 128'(mem_rd_addr), 128'(exp_addr_q.pop_front()));
      end
      if (done) done_seen++;
    end
    prev_stall = valid_out && !ready_in && !rst;
    prev_point = point_out;
  end

  function automatic logic rdy(input int mode, input int cyc);
    case (mode)
      1:       return cyc[0];
      2:       return (cyc > 10);
      default: return 1'b1;
    endcase
  endfunction

  task automatic check_reset_outputs(input string name);
    check(name, {valid_out, mem_rd_en, busy, done, 118'(mem_rd_addr)},
          {4'b0000, 118'd0});
    check({name, "_point"}, point_out, INVALID_POINT);
  endtask

  // mode: 0 ready held high, 1 ready toggling, 2 ready low for 10 cycles.
  task automatic run_frame(input int len, input int mode, input bit abort_at2,
                           input bit mid_start);
    int cyc, reads, vcyc, first_v, xfers, limit;
    bit got_done;
    for (int i = 0; i < len; i++) begin
      exp_pt_q.push_back(pt(i));
      exp_addr_q.push_back(i);
    end
    if (len > 0) for (int i = 0; i < PAD; i++) exp_pt_q.push_back(INVALID_POINT);
    if (!abort_at2) exp_done++;
    limit = len * 3 + 60;
    cyc = 0; reads = 0; vcyc = 0; first_v = -1; xfers = 0; got_done = 1'b0;

    @(posedge clk); #1;
    start     = 1'b1;
    frame_len = (ADDR_W + 1)'(len);
    ready_in  = rdy(mode, 0);
    while (!got_done && cyc < limit) begin
      @(posedge clk); #1;
      start = mid_start && (cyc == 2);
      if (start) frame_len = (ADDR_W + 1)'(7);
      cyc++;
      ready_in = rdy(mode, cyc);
      if (cyc == 1) check("busy_after_start", 128'(busy), 128'(1));
      @(negedge clk);
      if (valid_out) begin
        vcyc++;
        if (first_v < 0) first_v = cyc;
      end
      if (valid_out && ready_in) xfers++;
      if (mem_rd_en) reads++;
      if (mode == 2 && cyc == 10) check("reads_while_stalled", 128'(reads), 128'(2));
      if (done) got_done = 1'b1;
      if (abort_at2 && xfers == 2) begin
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("outputs_after_midframe_rst");
        rst = 1'b0;
        exp_pt_q.delete();
        exp_addr_q.delete();
        return;
      end
    end
    start = 1'b0;
    check("frame_done_seen", 128'(got_done), 128'(1));
    check("frame_read_count", 128'(reads), 128'(len));
    if (len == 0) begin
      check("zero_len_done_cycle", 128'(cyc), 128'(1));
      check("zero_len_no_valid", 128'(vcyc), 128'(0));
    end
    if (len == 3 && mode == 0) begin
      check("first_valid_cycle", 128'(first_v), 128'(3));
      check("valid_cycle_count", 128'(vcyc), 128'(7));
      check("done_after_last_valid", 128'(cyc), 128'(10));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("outputs_in_reset");
    rst = 1'b0;

    run_frame(3, 0, 1'b0, 1'b0);      // A,B,C then 4 pads, done next cycle
    run_frame(5, 1, 1'b0, 1'b0);      // toggling ready, stalls must hold
    run_frame(0, 0, 1'b0, 1'b0);      // empty frame: done only
    run_frame(4, 0, 1'b0, 1'b1);      // second start mid-frame is ignored
    run_frame(8, 0, 1'b1, 1'b0);      // reset after 2nd transfer
    run_frame(2, 0, 1'b0, 1'b0);      // clean frame after the abort
    run_frame(4, 2, 1'b0, 1'b0);      // ready low 10 cycles at frame start
    run_frame(1 << ADDR_W, 0, 1'b0, 1'b0);  // full memory, no wrap

    repeat (3) @(posedge clk);
    #1;
    check("points_left_in_scoreboard", 128'(exp_pt_q.size()), 128'(0));
    check("reads_left_in_scoreboard", 128'(exp_addr_q.size()), 128'(0));
    check("done_pulse_count", 128'(done_seen), 128'(exp_done));
    check("idle_at_end", 128'({busy, valid_out, mem_rd_en}), 128'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
